// File: rtl/input_value_parser.sv
// UART RX frame parser: "S<led hex>,<element hex>\n" -> led_data / element_data.
// Optional inter-byte timeout enabled by defining INPUT_PARSER_TIMEOUT_EN.
module input_value_parser #(
  parameter int DATA_WIDTH     = 8,
  parameter int LED_COUNT      = 16,
  parameter int ELEMENT_COUNT  = 12,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ena,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [LED_COUNT-1:0]     led_data,
  output logic [ELEMENT_COUNT-1:0] element_data,
  output logic                     frame_valid,
  output logic                     frame_error
);

  localparam int LED_DIGITS  = LED_COUNT / 4;
  localparam int ELEM_DIGITS = ELEMENT_COUNT / 4;
  localparam logic [3:0] LED_LAST  = 4'(LED_DIGITS - 1);
  localparam logic [3:0] ELEM_LAST = 4'(ELEM_DIGITS - 1);

  localparam logic [DATA_WIDTH-1:0] CHAR_S     = DATA_WIDTH'(8'h53);
  localparam logic [DATA_WIDTH-1:0] CHAR_COMMA = DATA_WIDTH'(8'h2C);
  localparam logic [DATA_WIDTH-1:0] CHAR_LF    = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] CHAR_0     = DATA_WIDTH'(8'h30);
  localparam logic [DATA_WIDTH-1:0] CHAR_9     = DATA_WIDTH'(8'h39);
  localparam logic [DATA_WIDTH-1:0] CHAR_UA    = DATA_WIDTH'(8'h41);
  localparam logic [DATA_WIDTH-1:0] CHAR_UF    = DATA_WIDTH'(8'h46);
  localparam logic [DATA_WIDTH-1:0] CHAR_LA    = DATA_WIDTH'(8'h61);
  localparam logic [DATA_WIDTH-1:0] CHAR_LF_HEX = DATA_WIDTH'(8'h66);
  localparam logic [DATA_WIDTH-1:0] TEN        = DATA_WIDTH'(10);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LED,
    ST_SEP,
    ST_ELEM,
    ST_END,
    ST_COMMIT
  } state_t;

  state_t                   state_reg, state_next;
  logic [LED_COUNT-1:0]     led_shadow_reg, led_shadow_next;
  logic [ELEMENT_COUNT-1:0] elem_shadow_reg, elem_shadow_next;
  logic [3:0]               digit_cnt_reg, digit_cnt_next;
  logic [LED_COUNT-1:0]     led_data_reg, led_data_next;
  logic [ELEMENT_COUNT-1:0] element_data_reg, element_data_next;
  logic                     frame_error_reg, frame_error_next;

  logic       accept;
  logic [4:0] hex_dec;
  logic       hex_ok;
  logic [3:0] nibble;
  logic       timeout_hit;
  logic       abort;

  // Returns {valid, nibble}; upper and lower case letters decode identically.
  function automatic logic [4:0] hex_decode(input logic [DATA_WIDTH-1:0] b);
    logic [4:0] r;
    r = '0;
    if (b >= CHAR_0 && b <= CHAR_9)
      r = {1'b1, 4'(b - CHAR_0)};
    else if (b >= CHAR_UA && b <= CHAR_UF)
      r = {1'b1, 4'(b - CHAR_UA + TEN)};
    else if (b >= CHAR_LA && b <= CHAR_LF_HEX)
      r = {1'b1, 4'(b - CHAR_LA + TEN)};
    return r;
  endfunction

  assign rx_ready     = ena & (state_reg != ST_COMMIT);
  assign accept       = rx_valid & rx_ready;
  assign hex_dec      = hex_decode(rx_data);
  assign hex_ok       = hex_dec[4];
  assign nibble       = hex_dec[3:0];
  assign frame_valid  = (state_reg == ST_COMMIT);
  assign frame_error  = frame_error_reg;
  assign led_data     = led_data_reg;
  assign element_data = element_data_reg;

`ifdef INPUT_PARSER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] timeout_cnt_reg, timeout_cnt_next;

  // Counts idle cycles inside a frame; frozen while ena is low.
  always_comb begin
    timeout_cnt_next = timeout_cnt_reg;
    timeout_hit      = 1'b0;
    if (accept || state_reg == ST_IDLE || state_reg == ST_COMMIT) begin
      timeout_cnt_next = '0;
    end else if (ena) begin
      if (timeout_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit      = 1'b1;
        timeout_cnt_next = '0;
      end else begin
        timeout_cnt_next = timeout_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) timeout_cnt_reg <= '0;
    else          timeout_cnt_reg <= timeout_cnt_next;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_next        = state_reg;
    led_shadow_next   = led_shadow_reg;
    elem_shadow_next  = elem_shadow_reg;
    digit_cnt_next    = digit_cnt_reg;
    led_data_next     = led_data_reg;
    element_data_next = element_data_reg;
    frame_error_next  = 1'b0;
    abort             = timeout_hit;

    case (state_reg)
      ST_IDLE: begin
        if (accept && rx_data == CHAR_S) begin
          state_next       = ST_LED;
          led_shadow_next  = '0;
          elem_shadow_next = '0;
          digit_cnt_next   = '0;
        end
      end
      ST_LED: begin
        if (accept) begin
          if (hex_ok) begin
            led_shadow_next = (led_shadow_reg << 4) | LED_COUNT'(nibble);
            if (digit_cnt_reg == LED_LAST) begin
              digit_cnt_next = '0;
              state_next     = ST_SEP;
            end else begin
              digit_cnt_next = digit_cnt_reg + 1'b1;
            end
          end else begin
            abort = 1'b1;
          end
        end
      end
      ST_SEP: begin
        if (accept) begin
          if (rx_data == CHAR_COMMA) begin
            state_next     = ST_ELEM;
            digit_cnt_next = '0;
          end else begin
            abort = 1'b1;
          end
        end
      end
      ST_ELEM: begin
        if (accept) begin
          if (hex_ok) begin
            elem_shadow_next = (elem_shadow_reg << 4) | ELEMENT_COUNT'(nibble);
            if (digit_cnt_reg == ELEM_LAST) begin
              digit_cnt_next = '0;
              state_next     = ST_END;
            end else begin
              digit_cnt_next = digit_cnt_reg + 1'b1;
            end
          end else begin
            abort = 1'b1;
          end
        end
      end
      ST_END: begin
        if (accept) begin
          if (rx_data == CHAR_LF) state_next = ST_COMMIT;
          else                    abort      = 1'b1;
        end
      end
      // COMMIT consumes no byte, so it always completes in one cycle.
      ST_COMMIT: begin
        led_data_next     = led_shadow_reg;
        element_data_next = elem_shadow_reg;
        state_next        = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // An offending 'S' doubles as the start of the next frame.
    if (abort) begin
      frame_error_next = 1'b1;
      led_shadow_next  = '0;
      elem_shadow_next = '0;
      digit_cnt_next   = '0;
      state_next       = (accept && rx_data == CHAR_S) ? ST_LED : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      led_shadow_reg   <= '0;
      elem_shadow_reg  <= '0;
      digit_cnt_reg    <= '0;
      led_data_reg     <= '0;
      element_data_reg <= '0;
      frame_error_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      led_shadow_reg   <= led_shadow_next;
      elem_shadow_reg  <= elem_shadow_next;
      digit_cnt_reg    <= digit_cnt_next;
      led_data_reg     <= led_data_next;
      element_data_reg <= element_data_next;
      frame_error_reg  <= frame_error_next;
    end
  end

endmodule
